// File: rtl/mem_stage_if.sv
// Data-cache word-access handshake between the MEM stage (master) and the cache (slave).
interface mem_stage_if #(
  parameter int BIT_W  = 32,
  parameter int ADDR_W = 30
);
  logic              dc_ren;
  logic              dc_wen;
  logic [ADDR_W-1:0] dc_addr;
  logic [BIT_W-1:0]  dc_wdata;
  logic [BIT_W-1:0]  dc_rdata;
  logic              dc_stall;

  modport master (
    output dc_ren, dc_wen, dc_addr, dc_wdata,
    input  dc_rdata, dc_stall
  );

  modport slave (
    input  dc_ren, dc_wen, dc_addr, dc_wdata,
    output dc_rdata, dc_stall
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: word load/store over the cache handshake, registered MEM/WB outputs.
// Latency 1 cycle for ALU ops, 2 + cache-stall cycles for memory ops; stall_o freezes upstream meanwhile.
module mem_stage #(
  parameter int BIT_W  = 32,
  parameter int ADDR_W = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIT_W-1:0] alu_res_i,
  input  logic [BIT_W-1:0] st_dat_i,
  input  logic [4:0]       rd_i,
  input  logic             memrd_i,
  input  logic             memwr_i,
  input  logic             mem2reg_i,
  input  logic             regwr_i,
  mem_stage_if.master      dc,
  output logic             stall_o,
  output logic [BIT_W-1:0] wb_data_o,
  output logic [4:0]       wb_rd_o,
  output logic             wb_regwr_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BIT_W-1:0]  wdata_q, wdata_d;
  logic [BIT_W-1:0]  wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_regwr_q, wb_regwr_d;

  logic mem_op;
  logic stall;
  logic load_done;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^alu_res_i[1:0];

  always_comb begin
    state_d    = state_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_regwr_d = 1'b0;

    mem_op    = memrd_i | memwr_i;
    stall     = ((state_q == IDLE) & mem_op) | ((state_q == ACCESS) & dc.dc_stall);
    load_done = (state_q == ACCESS) & ~dc.dc_stall & ren_q;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d = ACCESS;
          // A simultaneous read+write request is executed as a plain store.
          ren_d   = memrd_i & ~memwr_i;
          wen_d   = memwr_i;
          addr_d  = alu_res_i[ADDR_W+1:2];
          wdata_d = st_dat_i;
        end
      end
      ACCESS: begin
        if (!dc.dc_stall) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stalled cycles insert a bubble; data/rd hold so only regwr needs clearing.
    if (!stall) begin
      wb_rd_d    = rd_i;
      wb_regwr_d = regwr_i;
      wb_data_d  = (mem2reg_i & load_done) ? dc.dc_rdata : alu_res_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_regwr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_regwr_q <= wb_regwr_d;
    end
  end

  assign dc.dc_ren   = ren_q;
  assign dc.dc_wen   = wen_q;
  assign dc.dc_addr  = addr_q;
  assign dc.dc_wdata = wdata_q;

  // Held in reset the stage must not freeze upstream even if a memory op is presented.
  assign stall_o    = stall & rst_n;
  assign wb_data_o  = wb_data_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_regwr_o = wb_regwr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of ALU vectors plus load/store/reset sequences.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_res_i, st_dat_i;
  logic [4:0]  rd_i;
  logic        memrd_i, memwr_i, mem2reg_i, regwr_i;
  logic        stall_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_regwr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.BIT_W(32), .ADDR_W(30)) dc ();

  mem_stage #(.BIT_W(32), .ADDR_W(30)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_res_i  (alu_res_i),
    .st_dat_i   (st_dat_i),
    .rd_i       (rd_i),
    .memrd_i    (memrd_i),
    .memwr_i    (memwr_i),
    .mem2reg_i  (mem2reg_i),
    .regwr_i    (regwr_i),
    .dc         (dc),
    .stall_o    (stall_o),
    .wb_data_o  (wb_data_o),
    .wb_rd_o    (wb_rd_o),
    .wb_regwr_o (wb_regwr_o)
  );

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        regwr;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_regwr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_res_i = '0; st_dat_i = '0; rd_i = '0;
    memrd_i = 1'b0; memwr_i = 1'b0; mem2reg_i = 1'b0; regwr_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls;
    int pulses;

    vecs[0] = '{32'h0000_1234, 5'd5,  1'b1, 32'h0000_1234, 5'd5,  1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1};
    vecs[2] = '{32'h0000_0001, 5'd0,  1'b0, 32'h0000_0001, 5'd0,  1'b0};
    vecs[3] = '{32'h8000_0000, 5'd12, 1'b1, 32'h8000_0000, 5'd12, 1'b1};

    rst_n = 1'b0;
    idle_inputs();
    dc.dc_stall = 1'b0;
    dc.dc_rdata = '0;
    #3;
    check("rst_stall", stall_o, 0);
    check("rst_ren", dc.dc_ren, 0);
    check("rst_wen", dc.dc_wen, 0);
    check("rst_addr", dc.dc_addr, 0);
    check("rst_wdata", dc.dc_wdata, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_wb_rd", wb_rd_o, 0);
    check("rst_wb_regwr", wb_regwr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // ALU-only ops complete in one cycle with no stall
    for (int i = 0; i < 4; i++) begin
      alu_res_i = vecs[i].alu;
      rd_i      = vecs[i].rd;
      regwr_i   = vecs[i].regwr;
      @(negedge clk);
      check("alu_stall", stall_o, 0);
      check("alu_ren", dc.dc_ren, 0);
      next_cycle();
      check("alu_wb_data", wb_data_o, vecs[i].exp_data);
      check("alu_wb_rd", wb_rd_o, {27'd0, vecs[i].exp_rd});
      check("alu_wb_regwr", wb_regwr_o, {31'd0, vecs[i].exp_regwr});
    end

    // Load with 3 cache-stall cycles
    idle_inputs();
    alu_res_i = 32'h0000_0040; rd_i = 5'd7; memrd_i = 1'b1; mem2reg_i = 1'b1; regwr_i = 1'b1;
    stalls = 0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      dc.dc_stall = (c >= 1 && c <= 3);
      dc.dc_rdata = (c == 4) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      @(negedge clk);
      if (stall_o) stalls++;
      if (c >= 1) begin
        check("ld_ren", dc.dc_ren, 1);
        check("ld_wen", dc.dc_wen, 0);
        check("ld_addr", dc.dc_addr, 32'h10);
      end
      if (c < 4) check("ld_rd_hold", wb_rd_o, 12);
      next_cycle();
      if (wb_regwr_o) pulses++;
      if (c == 4) begin
        check("ld_wb_data", wb_data_o, 32'hDEAD_BEEF);
        check("ld_wb_rd", wb_rd_o, 7);
      end
    end
    check("ld_stall_cycles", stalls, 4);
    check("ld_wb_pulses", pulses, 1);
    check("ld_ren_after", dc.dc_ren, 0);

    // ALU op right behind the load
    dc.dc_stall = 1'b0;
    idle_inputs();
    alu_res_i = 32'h0000_0055; rd_i = 5'd9; regwr_i = 1'b1;
    @(negedge clk);
    check("b2b_stall", stall_o, 0);
    next_cycle();
    check("b2b_wb_data", wb_data_o, 32'h55);
    check("b2b_wb_rd", wb_rd_o, 9);
    check("b2b_wb_regwr", wb_regwr_o, 1);
    idle_inputs();
    next_cycle();
    check("b2b_no_dup", wb_regwr_o, 0);

    // Store, zero-stall cache
    alu_res_i = 32'h0000_0100; st_dat_i = 32'hCAFE_F00D; memwr_i = 1'b1;
    @(negedge clk);
    check("st_issue_stall", stall_o, 1);
    check("st_issue_wen", dc.dc_wen, 0);
    next_cycle();
    check("st_wen", dc.dc_wen, 1);
    check("st_ren", dc.dc_ren, 0);
    check("st_addr", dc.dc_addr, 32'h40);
    check("st_wdata", dc.dc_wdata, 32'hCAFE_F00D);
    check("st_done_stall", stall_o, 0);
    check("st_bubble", wb_regwr_o, 0);
    next_cycle();
    check("st_wen_after", dc.dc_wen, 0);
    check("st_no_wb", wb_regwr_o, 0);
    idle_inputs();

    // Read+write together acts as store; byte-offset bits ignored
    alu_res_i = 32'h0000_000B; st_dat_i = 32'h0000_0077; memrd_i = 1'b1; memwr_i = 1'b1;
    next_cycle();
    check("rw_wen", dc.dc_wen, 1);
    check("rw_ren", dc.dc_ren, 0);
    check("rw_addr", dc.dc_addr, 32'h2);
    next_cycle();
    idle_inputs();
    dc.dc_stall = 1'b1;
    #1;
    check("idle_stall_ign", stall_o, 0);
    next_cycle();
    check("idle_stall_ren", dc.dc_ren, 0);
    check("idle_stall_wen", dc.dc_wen, 0);
    check("idle_stall_ign2", stall_o, 0);

    // Reset asserted mid-ACCESS
    alu_res_i = 32'h0000_0200; rd_i = 5'd3; memrd_i = 1'b1; mem2reg_i = 1'b1; regwr_i = 1'b1;
    next_cycle();
    check("rs_ren_pre", dc.dc_ren, 1);
    check("rs_stall_pre", stall_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_ren", dc.dc_ren, 0);
    check("rs_wen", dc.dc_wen, 0);
    check("rs_stall", stall_o, 0);
    check("rs_wb_regwr", wb_regwr_o, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    check("rs_idle_stall", stall_o, 0);
    check("rs_idle_ren", dc.dc_ren, 0);
    check("rs_idle_wb", wb_regwr_o, 0);
    dc.dc_stall = 1'b0;
    alu_res_i = 32'h0000_00A5; rd_i = 5'd4; regwr_i = 1'b1;
    next_cycle();
    check("rs_alu_data", wb_data_o, 32'hA5);
    check("rs_alu_regwr", wb_regwr_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
